// File: rtl/tmc_spi_sequencer.sv
// rtl/tmc_spi_sequencer.sv - host/poll transaction sequencer for the TMC 40-bit SPI master
module tmc_spi_sequencer #(
  parameter bit         POLL_EN        = 1'b1,
  parameter logic [6:0] POLL_ADDR      = 7'h6F,
  parameter int         POLL_CYCLES    = 5_000_000,
  parameter int         GAP_CYCLES     = 100,
  parameter int         TIMEOUT_CYCLES = 200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [6:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_status,
  output logic        rsp_err,
  output logic        poll_update,
  output logic [31:0] poll_data,
  output logic [7:0]  last_status,
  output logic        busy,
  output logic        spi_start,
  output logic [39:0] spi_mosi_data,
  input  logic        spi_done,
  input  logic [39:0] spi_miso_data
);
  localparam int PW = $clog2(POLL_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, GAP, RESP} state_t;

  state_t        state, state_nxt;
  logic          out_en;
  logic          job_wr, job_poll, phase, err;
  logic [39:0]   miso_q;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;
  logic          poll_pending;
  logic          accept, take_poll, tmo_hit, gap_hit, poll_wrap;

  assign tmo_hit   = (tmo_cnt >= TMO_LAST);
  assign gap_hit   = (gap_cnt == GAP_LAST);
  assign poll_wrap = POLL_EN && (poll_cnt == POLL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = out_en && (state == IDLE);
    busy      = (state != IDLE);
    spi_start = (state == START);
    accept    = cmd_valid && cmd_ready;
    take_poll = POLL_EN && cmd_ready && poll_pending && !cmd_valid;
    unique case (state)
      IDLE:    if (accept || take_poll) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (spi_done)     state_nxt = GAP;
        else if (tmo_hit) state_nxt = RESP;
      end
      GAP:     if (gap_hit) state_nxt = (!job_wr && !phase) ? START : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en        <= 1'b0;
      job_wr        <= 1'b0;
      job_poll      <= 1'b0;
      phase         <= 1'b0;
      err           <= 1'b0;
      miso_q        <= '0;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
      poll_cnt      <= '0;
      poll_pending  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_status    <= '0;
      rsp_err       <= 1'b0;
      poll_update   <= 1'b0;
      poll_data     <= '0;
      last_status   <= '0;
      spi_mosi_data <= '0;
    end else begin
      out_en      <= 1'b1;
      rsp_valid   <= 1'b0;
      poll_update <= 1'b0;
      if (POLL_EN) begin
        poll_cnt <= poll_wrap ? '0 : poll_cnt + PW'(1);
        // A wrap always leaves one request outstanding, even when the previous one is taken now
        if (poll_wrap)      poll_pending <= 1'b1;
        else if (take_poll) poll_pending <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (accept || take_poll) begin
            job_wr   <= accept && cmd_wr;
            job_poll <= !accept;
            phase    <= 1'b0;
            err      <= 1'b0;
            miso_q   <= '0;
            if (accept) spi_mosi_data <= {cmd_wr, cmd_addr, cmd_wr ? cmd_wdata : 32'h0};
            else        spi_mosi_data <= {1'b0, POLL_ADDR, 32'h0};
          end
        end
        START: tmo_cnt <= TW'(1);
        WAIT: begin
          if (spi_done) begin
            miso_q      <= spi_miso_data;
            last_status <= spi_miso_data[39:32];
            gap_cnt     <= '0;
          end else if (tmo_hit) begin
            err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        GAP: begin
          if (gap_hit) begin
            if (!job_wr) phase <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        RESP: begin
          if (!job_poll) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= miso_q[31:0];
            rsp_status <= miso_q[39:32];
            rsp_err    <= err;
          end else if (!err) begin
            poll_update <= 1'b1;
            poll_data   <= miso_q[31:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tmc_spi_sequencer.sv
// tb/tb_tmc_spi_sequencer.sv - directed/random bench with a pipelined-read TMC chip model
module tb_tmc_spi_sequencer;
  localparam int GAP   = 20;
  localparam int TMO   = 500;
  localparam int POLLC = 1000;
  localparam logic [6:0] PADDR = 7'h6F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_status;
  logic        rsp_err;
  logic        poll_update;
  logic [31:0] poll_data;
  logic [7:0]  last_status;
  logic        busy;
  logic        spi_start;
  logic [39:0] spi_mosi_data;
  logic        spi_done = 1'b0;
  logic [39:0] spi_miso_data = '0;

  always #5 clk = ~clk;

  tmc_spi_sequencer #(
    .POLL_EN(1'b1), .POLL_ADDR(PADDR), .POLL_CYCLES(POLLC),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_err(rsp_err),
    .poll_update(poll_update), .poll_data(poll_data), .last_status(last_status),
    .busy(busy), .spi_start(spi_start), .spi_mosi_data(spi_mosi_data),
    .spi_done(spi_done), .spi_miso_data(spi_miso_data)
  );

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chip model: reply data is the register addressed by the previous datagram
  logic [31:0] regs [128];
  logic [6:0]  prev_addr = '0;
  bit          mute = 1'b0;
  int          lat_min = 2, lat_max = 8;
  logic [7:0]  status_q[$];
  logic [39:0] last_reply = '0;
  logic [39:0] mosi_log[$];
  int          start_log[$];
  int          done_log[$];
  int          inject_req = 0, inject_ack = 0;

  initial begin
    logic [39:0] d;
    int lat;
    for (int i = 0; i < 128; i++) regs[i] = $urandom;
    forever begin
      @(negedge clk);
      if (rst_n && spi_start) begin
        d = spi_mosi_data;
        mosi_log.push_back(d);
        start_log.push_back(cyc);
        if (mute) begin
          done_log.push_back(-1);
        end else begin
          lat = $urandom_range(lat_max, lat_min);
          repeat (lat) @(negedge clk);
          last_reply[31:0]  = regs[prev_addr];
          last_reply[39:32] = (status_q.size() > 0) ? status_q.pop_front() : 8'($urandom);
          if (d[39]) regs[d[38:32]] = d[31:0];
          prev_addr = d[38:32];
          spi_miso_data = last_reply;
          spi_done = 1'b1;
          done_log.push_back(cyc);
          @(negedge clk);
          spi_done = 1'b0;
        end
      end else if (inject_req != inject_ack) begin
        inject_ack = inject_req;
        spi_miso_data = 40'hEE_DEAD_BEEF;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
      end
    end
  end

  int n_rsp = 0, n_poll = 0;
  always @(negedge clk) begin
    if (rsp_valid)   n_rsp  <= n_rsp + 1;
    if (poll_update) n_poll <= n_poll + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int acc_cyc = 0, got_rsp_cyc = 0;

  task automatic wait_rsp(input int lim);
    int t = 0;
    while (!rsp_valid && t < lim) begin @(negedge clk); t++; end
    got_rsp_cyc = cyc;
    check("rsp_arrived", rsp_valid, 1);
  endtask

  task automatic host_cmd(input logic wr, input logic [6:0] addr, input logic [31:0] wd);
    int t = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd;
    while (!cmd_ready && t < 5000) begin @(negedge clk); t++; end
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(6000);
  endtask

  task automatic wait_poll(input string tag);
    int t = 0;
    @(negedge clk);
    while (!poll_update && t < 2 * POLLC + 500) begin @(negedge clk); t++; end
    check(tag, poll_update, 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, np0, nr0, p1, p2, target, rel_cyc;
    logic [6:0] a;
    logic [31:0] wd;
    logic w;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_flags", {rsp_valid, rsp_err, poll_update, busy, spi_start}, 0);
    check("rst_bytes", {rsp_status, last_status}, 0);
    check("rst_data", {rsp_data, poll_data}, 0);
    check("rst_mosi", spi_mosi_data, 0);
    rst_n = 1'b1;
    rel_cyc = cyc;
    @(negedge clk);
    check("ready_after_reset", {cmd_ready, busy}, 2'b10);

    status_q.push_back(8'h01);
    n0 = mosi_log.size();
    host_cmd(1'b1, 7'h10, 32'h0007_1F0A);
    check("wr_transfers", mosi_log.size() - n0, 1);
    check("wr_mosi", mosi_log[n0], 40'h90_0007_1F0A);
    check("wr_start_lat", start_log[n0] - acc_cyc, 1);
    check("wr_rsp_lat", got_rsp_cyc - done_log[n0], GAP + 2);
    check("wr_status", {rsp_err, rsp_status}, {1'b0, 8'h01});
    check("wr_data", rsp_data, last_reply[31:0]);
    check("wr_last_status", last_status, 8'h01);

    regs[7'h6C] = 32'h1234_5678;
    status_q.push_back(8'h5A);
    status_q.push_back(8'h03);
    n0 = mosi_log.size();
    host_cmd(1'b0, 7'h6C, 32'hDEAD_BEEF);
    check("rd_transfers", mosi_log.size() - n0, 2);
    check("rd_mosi0", mosi_log[n0], 40'h6C_0000_0000);
    check("rd_mosi1", mosi_log[n0+1], 40'h6C_0000_0000);
    check("rd_gap", (start_log[n0+1] - done_log[n0]) > GAP, 1);
    check("rd_data", rsp_data, 32'h1234_5678);
    check("rd_status", {rsp_err, rsp_status}, {1'b0, 8'h03});

    for (int i = 0; i < 8; i++) begin
      w  = 1'($urandom);
      a  = 7'($urandom);
      wd = $urandom;
      if (a == PADDR) a = 7'h01;
      host_cmd(w, a, wd);
      check("rnd_mosi", mosi_log[$], {w, a, w ? wd : 32'h0});
      check("rnd_status", {rsp_err, rsp_status}, {1'b0, last_reply[39:32]});
      check("rnd_data", rsp_data, w ? last_reply[31:0] : regs[a]);
    end

    regs[PADDR] = 32'h8000_0001;
    @(negedge clk);
    nr0 = n_rsp;
    wait_poll("poll_a_seen");
    wait_poll("poll_b_seen");
    p1 = cyc;
    check("poll_data", poll_data, 32'h8000_0001);
    check("poll_mosi", mosi_log[$], 40'h6F_0000_0000);
    wait_poll("poll_c_seen");
    p2 = cyc;
    check("poll_interval", (p2 - p1 >= POLLC - 14) && (p2 - p1 <= POLLC + 14), 1);
    @(negedge clk);
    check("poll_no_rsp", n_rsp - nr0, 0);

    // Host request lands in the cycle the poll request first shows up
    target = rel_cyc + POLLC * ((cyc - rel_cyc) / POLLC + 1);
    np0 = n_poll;
    a = 7'($urandom_range(7'h5F, 7'h20));
    lat_min = 490;
    lat_max = 490;
    while (cyc != target) @(negedge clk);
    n0 = mosi_log.size();
    host_cmd(1'b0, a, 32'h0);
    lat_min = 2;
    lat_max = 8;
    check("cont_host_first", mosi_log[n0], {1'b0, a, 32'h0});
    check("cont_start_lat", start_log[n0] - acc_cyc, 1);
    check("cont_data", rsp_data, regs[a]);
    check("cont_no_poll_during_host", n_poll - np0, 0);
    while (cyc != target + 2 * POLLC - 1) @(negedge clk);
    check("cont_poll_jobs", n_poll - np0, 1);
    check("cont_poll_xfers", mosi_log.size() - (n0 + 2), 2);
    check("cont_poll_mosi", mosi_log[$], 40'h6F_0000_0000);

    wait_poll("pre_tmo_poll");
    @(negedge clk);
    mute = 1'b1;
    n0 = mosi_log.size();
    host_cmd(1'b1, 7'h22, $urandom);
    check("tmo_err", rsp_err, 1);
    check("tmo_lat", got_rsp_cyc - start_log[n0], TMO + 1);
    check("tmo_xfers", mosi_log.size() - n0, 1);
    @(negedge clk);
    check("tmo_idle", {busy, cmd_ready}, 2'b01);
    mute = 1'b0;
    a = 7'h33;
    host_cmd(1'b0, a, 32'h0);
    check("post_tmo_err", rsp_err, 0);
    check("post_tmo_data", rsp_data, regs[a]);

    inject_req++;
    repeat (3) @(negedge clk);
    check("spurious_status", last_status, last_reply[39:32]);
    check("spurious_idle", {busy, cmd_ready}, 2'b01);

    mute = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 7'h44; cmd_wdata = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", busy, 1);
    nr0 = n_rsp;
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {cmd_ready, rsp_valid, rsp_err, poll_update, busy, spi_start}, 0);
    check("mid_rst_data", {rsp_data, poll_data, rsp_status, last_status}, 0);
    check("mid_rst_mosi", spi_mosi_data, 0);
    repeat (5) @(negedge clk);
    mute = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", cmd_ready, 1);
    @(negedge clk);
    check("mid_rst_no_rsp", n_rsp - nr0, 0);
    status_q.push_back(8'h42);
    n0 = mosi_log.size();
    host_cmd(1'b1, 7'h15, 32'hCAFE_0123);
    check("post_rst_mosi", mosi_log[n0], 40'h95_CAFE_0123);
    check("post_rst_status", {rsp_err, rsp_status}, {1'b0, 8'h42});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
